// File: rtl/dct2d_seq_ctrl_if.sv
// Control bus between the block-level handshake and the 2-D DCT sequencer.
// Latency: none (wires only).
// Backpressure: hold/abort travel master -> slave; status and strobes return slave -> master.
interface dct2d_seq_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              start;
  logic              hold;
  logic              abort;
  logic              ready;
  logic              busy;
  logic              pass_sel;
  logic [3:0]        cnt_clk;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              done;

  // Controller side (block-level user of the transform engine)
  modport master (
    output start, hold, abort,
    input  ready, busy, pass_sel, cnt_clk, rd_en, rd_addr, wr_en, wr_addr, done
  );

  // Sequencer side
  modport slave (
    input  start, hold, abort,
    output ready, busy, pass_sel, cnt_clk, rd_en, rd_addr, wr_en, wr_addr, done
  );
endinterface

// File: rtl/dct2d_seq_ctrl.sv
// Sequencer for the shared 8-point DCT datapath: row pass then column pass, per vector FETCH/COMPUTE/STORE.
// Latency: N_VEC*2*(N_PHASE+2) busy cycles plus one FINISH cycle carrying done; all outputs registered.
// Backpressure: hold freezes every register (strobes included); abort returns to IDLE and beats hold.
module dct2d_seq_ctrl #(
  parameter int N_PHASE = 3,
  parameter int N_VEC   = 8,
  parameter int ADDR_W  = 3
) (
  input logic             clk,
  input logic             rst_n,
  dct2d_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_STORE   = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [3:0]        LP_PH_LAST  = 4'(N_PHASE);
  localparam logic [ADDR_W-1:0] LP_VEC_LAST = ADDR_W'(N_VEC - 1);

  state_t            r_state, w_nxt_state;
  logic [3:0]        r_phase, w_nxt_phase;
  logic [ADDR_W-1:0] r_vec,   w_nxt_vec;
  logic              r_pass,  w_nxt_pass;

  logic              r_ready,    w_ready;
  logic              r_busy,     w_busy;
  logic              r_pass_sel, w_pass_sel;
  logic [3:0]        r_cnt_clk,  w_cnt_clk;
  logic              r_rd_en,    w_rd_en;
  logic [ADDR_W-1:0] r_rd_addr,  w_rd_addr;
  logic              r_wr_en,    w_wr_en;
  logic [ADDR_W-1:0] r_wr_addr,  w_wr_addr;
  logic              r_done,     w_done;

  // State and counter registers; reset leaves the sequencer idle with counters at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_vec   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_phase <= w_nxt_phase;
      r_vec   <= w_nxt_vec;
      r_pass  <= w_nxt_pass;
    end
  end

  // Next state and counters: abort (outside IDLE) wins, then hold freezes, else normal sequencing
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_vec   = r_vec;
    w_nxt_pass  = r_pass;
    if ((r_state != S_IDLE) && bus.abort) begin
      w_nxt_state = S_IDLE;
      w_nxt_phase = '0;
      w_nxt_vec   = '0;
      w_nxt_pass  = 1'b0;
    end else if (!bus.hold) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_nxt_state = S_FETCH;
            w_nxt_phase = '0;
            w_nxt_vec   = '0;
            w_nxt_pass  = 1'b0;
          end
        end
        S_FETCH: begin
          w_nxt_state = S_COMPUTE;
          w_nxt_phase = 4'd1;
        end
        S_COMPUTE: begin
          if (r_phase == LP_PH_LAST) begin
            w_nxt_state = S_STORE;
            w_nxt_phase = '0;
          end else begin
            w_nxt_phase = r_phase + 4'd1;
          end
        end
        S_STORE: begin
          if (r_vec != LP_VEC_LAST) begin
            w_nxt_vec   = r_vec + 1'b1;
            w_nxt_state = S_FETCH;
          end else if (!r_pass) begin
            // Row pass complete: restart at vector 0 with the column orientation
            w_nxt_vec   = '0;
            w_nxt_pass  = 1'b1;
            w_nxt_state = S_FETCH;
          end else begin
            w_nxt_state = S_FINISH;
          end
        end
        S_FINISH: begin
          w_nxt_state = S_IDLE;
          w_nxt_vec   = '0;
          w_nxt_pass  = 1'b0;
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_phase = '0;
          w_nxt_vec   = '0;
          w_nxt_pass  = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state, so each registered output matches the state it sits in
  always_comb begin
    w_ready    = (w_nxt_state == S_IDLE);
    w_busy     = (w_nxt_state == S_FETCH) || (w_nxt_state == S_COMPUTE) ||
                 (w_nxt_state == S_STORE);
    w_pass_sel = w_nxt_pass;
    w_cnt_clk  = (w_nxt_state == S_COMPUTE) ? w_nxt_phase : 4'd0;
    w_rd_en    = (w_nxt_state == S_FETCH);
    w_rd_addr  = (w_nxt_state == S_FETCH) ? w_nxt_vec : '0;
    w_wr_en    = (w_nxt_state == S_STORE);
    w_wr_addr  = (w_nxt_state == S_STORE) ? w_nxt_vec : '0;
    w_done     = (w_nxt_state == S_FINISH);
  end

  // Output registers; reset shows ready only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_pass_sel <= 1'b0;
      r_cnt_clk  <= 4'd0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_ready    <= w_ready;
      r_busy     <= w_busy;
      r_pass_sel <= w_pass_sel;
      r_cnt_clk  <= w_cnt_clk;
      r_rd_en    <= w_rd_en;
      r_rd_addr  <= w_rd_addr;
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      r_done     <= w_done;
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.pass_sel = r_pass_sel;
  assign bus.cnt_clk  = r_cnt_clk;
  assign bus.rd_en    = r_rd_en;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.done     = r_done;

endmodule
